// File: rtl/test_tone_gen.sv
// Multi-channel test-tone source: per-channel phase accumulators, shared waveform/attenuation.
// Two-stage pipeline, one frame per request, request-to-valid latency 2, never stalls.
module test_tone_gen #(
   parameter int NUM_CH   = 2,
   parameter int PHASE_W  = 24,
   parameter int SAMPLE_W = 16
) (
   input  logic                         i_clk,
   input  logic                         i_rst,
   input  logic [NUM_CH*PHASE_W-1:0]    i_fcw,
   input  logic [1:0]                   i_mode,
   input  logic [3:0]                   i_atten,
   input  logic                         i_sync,
   input  logic                         i_sample_req,
   output logic [NUM_CH*SAMPLE_W-1:0]   o_sample,
   output logic                         o_valid
);

   localparam logic [SAMPLE_W-1:0] C_MSB = {1'b1, {(SAMPLE_W-1){1'b0}}};
   localparam logic [SAMPLE_W-1:0] C_POS = {1'b0, {(SAMPLE_W-1){1'b1}}};
   // Negative square level is -(2^(SAMPLE_W-1)-1), keeping the square symmetric.
   localparam logic [SAMPLE_W-1:0] C_NEG = {1'b1, {(SAMPLE_W-2){1'b0}}, 1'b1};

   localparam logic [1:0] MODE_SAW = 2'd0;
   localparam logic [1:0] MODE_SQR = 2'd1;
   localparam logic [1:0] MODE_TRI = 2'd2;

   logic [3:0] r_atten;
   logic       r_v1;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_atten <= '0;
         r_v1    <= 1'b0;
         o_valid <= 1'b0;
      end else begin
         r_v1    <= i_sample_req;
         o_valid <= r_v1;
         if (i_sample_req)
            r_atten <= i_atten;
      end
   end

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      logic        [PHASE_W-1:0]  w_fcw;
      logic        [PHASE_W-1:0]  w_ph;
      logic        [SAMPLE_W-1:0] w_p;
      logic        [SAMPLE_W-1:0] w_q;
      logic        [SAMPLE_W-1:0] w_wave;
      logic        [PHASE_W-1:0]  r_phase;
      logic        [SAMPLE_W-1:0] r_wave;
      logic signed [SAMPLE_W-1:0] r_sample;

      assign w_fcw = i_fcw[c*PHASE_W +: PHASE_W];
      // Sync forces the sample (and the accumulation base) to phase 0.
      assign w_ph  = i_sync ? '0 : r_phase;
      assign w_p   = w_ph[PHASE_W-1 -: SAMPLE_W];
      assign w_q   = w_ph[PHASE_W-1] ? ~w_ph[PHASE_W-2 -: SAMPLE_W]
                                     :  w_ph[PHASE_W-2 -: SAMPLE_W];

      always_comb begin
         w_wave = '0;
         case (i_mode)
            MODE_SAW: w_wave = w_p ^ C_MSB;
            MODE_SQR: w_wave = w_ph[PHASE_W-1] ? C_NEG : C_POS;
            MODE_TRI: w_wave = w_q ^ C_MSB;
            default:  w_wave = '0;
         endcase
      end

      always_ff @(posedge i_clk or posedge i_rst) begin
         if (i_rst) begin
            r_phase  <= '0;
            r_wave   <= '0;
            r_sample <= '0;
         end else begin
            if (i_sample_req) begin
               r_phase <= w_ph + w_fcw;
               r_wave  <= w_wave;
            end else if (i_sync) begin
               r_phase <= '0;
            end
            if (r_v1)
               r_sample <= $signed(r_wave) >>> r_atten;
         end
      end

      assign o_sample[c*SAMPLE_W +: SAMPLE_W] = r_sample;
   end

endmodule

// File: tb/tb_test_tone_gen.sv
// Randomised and directed bench for test_tone_gen against a phase/waveform arithmetic model.
module tb_test_tone_gen;
   localparam int NCH = 2;
   localparam int PW  = 24;
   localparam int SW  = 16;

   logic                i_clk = 1'b0;
   logic                i_rst;
   logic [NCH*PW-1:0]   i_fcw;
   logic [1:0]          i_mode;
   logic [3:0]          i_atten;
   logic                i_sync;
   logic                i_sample_req;
   logic [NCH*SW-1:0]   o_sample;
   logic                o_valid;

   int total = 0;
   int bad   = 0;

   int unsigned        m_ph [NCH];
   int unsigned        m_fcw[NCH];
   logic [NCH*SW-1:0]  exp_q[$];
   logic               prev_req;
   logic [NCH*SW-1:0]  last_s;

   test_tone_gen #(.NUM_CH(NCH), .PHASE_W(PW), .SAMPLE_W(SW)) dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_fcw(i_fcw), .i_mode(i_mode), .i_atten(i_atten),
      .i_sync(i_sync), .i_sample_req(i_sample_req), .o_sample(o_sample), .o_valid(o_valid)
   );

   always #5 i_clk = ~i_clk;

   function automatic int wave_of(int unsigned ph, logic [1:0] mode);
      int unsigned p, q, m;
      p = ph >> (PW - SW);
      m = (ph >> (PW - 1)) & 1;
      q = (ph >> (PW - 1 - SW)) & ((1 << SW) - 1);
      case (mode)
         2'd0: return int'(p) - (1 << (SW - 1));
         2'd1: return (m != 0) ? -((1 << (SW - 1)) - 1) : ((1 << (SW - 1)) - 1);
         2'd2: begin
            if (m != 0) q = ((1 << SW) - 1) - q;
            return int'(q) - (1 << (SW - 1));
         end
         default: return 0;
      endcase
   endfunction

   task automatic model_reset();
      for (int c = 0; c < NCH; c++) m_ph[c] = 0;
      exp_q.delete();
      prev_req = 1'b0;
      last_s   = '0;
   endtask

   task automatic set_fcw(input int unsigned f0, input int unsigned f1);
      m_fcw[0] = f0 & 32'hFFFFFF;
      m_fcw[1] = f1 & 32'hFFFFFF;
      i_fcw    = {m_fcw[1][PW-1:0], m_fcw[0][PW-1:0]};
   endtask

   // Drives one cycle, advances the model, returns observed and expected outputs.
   task automatic tick(input logic req, input logic sync,
                       output logic gv, output logic [NCH*SW-1:0] gs,
                       output logic ev, output logic [NCH*SW-1:0] es);
      logic [NCH*SW-1:0] fr;
      int unsigned base;
      int v;
      i_sample_req = req;
      i_sync       = sync;
      fr = '0;
      for (int c = 0; c < NCH; c++) begin
         base = sync ? 0 : m_ph[c];
         v = wave_of(base, i_mode) >>> i_atten;
         fr[c*SW +: SW] = v[SW-1:0];
         m_ph[c] = req ? ((base + m_fcw[c]) & 32'hFFFFFF) : base;
      end
      if (req) exp_q.push_back(fr);
      ev = prev_req;
      prev_req = req;
      if (ev) begin
         es = exp_q.pop_front();
         last_s = es;
      end else begin
         es = last_s;
      end
      @(posedge i_clk);
      @(negedge i_clk);
      i_sample_req = 1'b0;
      i_sync       = 1'b0;
      gv = o_valid;
      gs = o_sample;
   endtask

   task automatic test_reset();
      i_rst = 1'b1;
      repeat (3) @(negedge i_clk);
      total++;
      if (o_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got %b want 0", o_valid); end
      total++;
      if (o_sample !== '0) begin bad++; $display("FAIL reset_sample got %h want 0", o_sample); end
      i_rst = 1'b0;
      model_reset();
   endtask

   task automatic test_saw_spaced();
      logic gv, ev; logic [NCH*SW-1:0] gs, es;
      logic [31:0] tbl[4] = '{32'h8000_8000, 32'h0000_C000, 32'h8000_0000, 32'h0000_4000};
      int k = 0;
      i_mode = 2'd0; i_atten = 4'd0;
      set_fcw(32'h400000, 32'h800000);
      for (int r = 0; r < 4; r++) begin
         for (int t = 0; t < 5; t++) begin
            tick(t == 0, 1'b0, gv, gs, ev, es);
            total++;
            if (gv !== ev) begin bad++; $display("FAIL saw_valid r%0d t%0d got %b want %b", r, t, gv, ev); end
            total++;
            if (gs !== es) begin bad++; $display("FAIL saw_model r%0d t%0d got %h want %h", r, t, gs, es); end
            if (gv === 1'b1 && k < 4) begin
               total++;
               if (gs !== tbl[k]) begin bad++; $display("FAIL saw_table %0d got %h want %h", k, gs, tbl[k]); end
               k++;
            end
         end
      end
      total++;
      if (k != 4) begin bad++; $display("FAIL saw_count got %0d want 4", k); end
   endtask

   task automatic test_back_to_back();
      logic gv, ev; logic [NCH*SW-1:0] gs, es;
      logic [15:0] sq[8]  = '{16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h8001, 16'h8001, 16'h8001, 16'h8001};
      logic [15:0] tri_t[8] = '{16'h8000, 16'hC000, 16'h0000, 16'h4000, 16'h7FFF, 16'h3FFF, 16'hFFFF, 16'hBFFF};
      int k;
      int run;
      set_fcw(32'h200000, 32'h200000);
      i_atten = 4'd0;
      for (int md = 1; md <= 2; md++) begin
         i_mode = 2'(md);
         tick(1'b0, 1'b1, gv, gs, ev, es);
         k = 0; run = 0;
         for (int t = 0; t < 11; t++) begin
            tick(t < 8, 1'b0, gv, gs, ev, es);
            total++;
            if (gv !== ev) begin bad++; $display("FAIL b2b_valid m%0d t%0d got %b want %b", md, t, gv, ev); end
            total++;
            if (gs !== es) begin bad++; $display("FAIL b2b_model m%0d t%0d got %h want %h", md, t, gs, es); end
            if (gv === 1'b1 && k < 8) begin
               total++;
               if (gs !== {2{(md == 1) ? sq[k] : tri_t[k]}}) begin
                  bad++; $display("FAIL b2b_table m%0d k%0d got %h", md, k, gs);
               end
               k++;
               if (t >= 1 && t <= 8) run++;
            end
         end
         total++;
         if (run != 8) begin bad++; $display("FAIL b2b_run m%0d got %0d want 8", md, run); end
      end
   endtask

   task automatic test_atten();
      logic gv, ev; logic [NCH*SW-1:0] gs, es;
      logic [31:0] tbl[3] = '{32'h3FFF_3FFF, 32'h3FFF_C000, 32'h0000_0000};
      logic [3:0]  at[3]  = '{4'd1, 4'd1, 4'd15};
      int k = 0;
      i_mode = 2'd1;
      set_fcw(32'h800000, 32'h0);
      tick(1'b0, 1'b1, gv, gs, ev, es);
      for (int t = 0; t < 5; t++) begin
         i_atten = (t < 3) ? at[t] : 4'd0;
         tick(t < 3, 1'b0, gv, gs, ev, es);
         total++;
         if (gv !== ev) begin bad++; $display("FAIL atten_valid t%0d got %b want %b", t, gv, ev); end
         total++;
         if (gs !== es) begin bad++; $display("FAIL atten_model t%0d got %h want %h", t, gs, es); end
         if (gv === 1'b1 && k < 3) begin
            total++;
            if (gs !== tbl[k]) begin bad++; $display("FAIL atten_table %0d got %h want %h", k, gs, tbl[k]); end
            k++;
         end
      end
   endtask

   task automatic test_wrap_sync();
      logic gv, ev; logic [NCH*SW-1:0] gs, es;
      logic [15:0] tbl[4] = '{16'h8000, 16'h7FFF, 16'h8000, 16'h7FFF};
      int k = 0;
      i_mode = 2'd0; i_atten = 4'd0;
      set_fcw(32'hFFFFFF, 32'hFFFFFF);
      tick(1'b0, 1'b1, gv, gs, ev, es);
      for (int t = 0; t < 6; t++) begin
         tick(t < 4, t == 2, gv, gs, ev, es);
         total++;
         if (gv !== ev) begin bad++; $display("FAIL wrap_valid t%0d got %b want %b", t, gv, ev); end
         total++;
         if (gs !== es) begin bad++; $display("FAIL wrap_model t%0d got %h want %h", t, gs, es); end
         if (gv === 1'b1 && k < 4) begin
            total++;
            if (gs !== {2{tbl[k]}}) begin bad++; $display("FAIL wrap_table %0d got %h want %h", k, gs, {2{tbl[k]}}); end
            k++;
         end
      end
   endtask

   task automatic test_mode_change();
      logic gv, ev; logic [NCH*SW-1:0] gs, es;
      logic [15:0] tbl[5] = '{16'h8000, 16'h0000, 16'h0000, 16'h0000, 16'hC000};
      logic        rq[8]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      int k = 0;
      i_mode = 2'd0; i_atten = 4'd0;
      set_fcw(32'h100000, 32'h100000);
      tick(1'b0, 1'b1, gv, gs, ev, es);
      for (int t = 0; t < 8; t++) begin
         if (t == 1) i_mode = 2'd3;
         if (t == 5) i_mode = 2'd0;
         tick(rq[t], 1'b0, gv, gs, ev, es);
         total++;
         if (gv !== ev) begin bad++; $display("FAIL mode_valid t%0d got %b want %b", t, gv, ev); end
         total++;
         if (gs !== es) begin bad++; $display("FAIL mode_model t%0d got %h want %h", t, gs, es); end
         if (gv === 1'b1 && k < 5) begin
            total++;
            if (gs !== {2{tbl[k]}}) begin bad++; $display("FAIL mode_table %0d got %h want %h", k, gs, {2{tbl[k]}}); end
            k++;
         end
      end
   endtask

   task automatic test_reset_midflight();
      logic gv, ev; logic [NCH*SW-1:0] gs, es;
      int seen = 0;
      i_mode = 2'd0; i_atten = 4'd0;
      set_fcw(32'h300000, 32'h500000);
      tick(1'b1, 1'b0, gv, gs, ev, es);
      tick(1'b1, 1'b0, gv, gs, ev, es);
      i_rst = 1'b1;
      for (int t = 0; t < 4; t++) begin
         @(negedge i_clk);
         if (o_valid !== 1'b0) seen++;
      end
      total++;
      if (seen != 0) begin bad++; $display("FAIL rstmid_valid pulses=%0d want 0", seen); end
      total++;
      if (o_sample !== '0) begin bad++; $display("FAIL rstmid_sample got %h want 0", o_sample); end
      i_rst = 1'b0;
      model_reset();
      for (int t = 0; t < 3; t++) begin
         tick(t == 0, 1'b0, gv, gs, ev, es);
         total++;
         if (gv !== ev) begin bad++; $display("FAIL rstmid_post_valid t%0d got %b want %b", t, gv, ev); end
         total++;
         if (gs !== es) begin bad++; $display("FAIL rstmid_post_model t%0d got %h want %h", t, gs, es); end
         if (t == 1) begin
            total++;
            if (gs !== 32'h8000_8000) begin bad++; $display("FAIL rstmid_first got %h want 80008000", gs); end
         end
      end
   endtask

   task automatic test_random();
      logic gv, ev; logic [NCH*SW-1:0] gs, es;
      for (int t = 0; t < 400; t++) begin
         if (t % 50 == 0) begin
            if ($urandom_range(0, 3) == 0) begin
               int unsigned f = $urandom;
               set_fcw(f, f);
            end else begin
               set_fcw($urandom, $urandom);
            end
         end
         i_mode  = 2'($urandom_range(0, 3));
         i_atten = 4'($urandom_range(0, 15));
         tick(($urandom_range(0, 9) < 7), ($urandom_range(0, 9) == 0), gv, gs, ev, es);
         total++;
         if (gv !== ev) begin bad++; $display("FAIL rand_valid t%0d got %b want %b", t, gv, ev); end
         total++;
         if (gs !== es) begin bad++; $display("FAIL rand_sample t%0d got %h want %h", t, gs, es); end
      end
   endtask

   initial begin
      i_rst = 1'b1; i_fcw = '0; i_mode = 2'd0; i_atten = 4'd0;
      i_sync = 1'b0; i_sample_req = 1'b0;
      model_reset();
      @(negedge i_clk);
      test_reset();
      test_saw_spaced();
      test_back_to_back();
      test_atten();
      test_wrap_sync();
      test_mode_change();
      test_random();
      test_reset_midflight();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/test_tone_gen.md
Name: test_tone_gen

Overview:
Multi-channel, multi-waveform test-tone source. It is the parametrised successor to the single saw-only accumulator tone. It feeds the audio output path (I2S/codec serialiser) during bring-up and loopback test. Each channel has its own phase accumulator and frequency control word. Waveform select and attenuation are shared by all channels. The block is fully pipelined with a sample-request/valid handshake.

Parameters:
NUM_CH, 2, number of independent channels (>=1); channel 0 occupies the LSBs of packed buses.
PHASE_W, 24, phase accumulator and FCW width; must be >= SAMPLE_W+1.
SAMPLE_W, 16, signed two's-complement output sample width per channel; must be >= 16.

Ports:
i_clk  in  1  system clock
i_rst  in  1  reset; asynchronous, active-high
i_fcw  in  NUM_CH*PHASE_W  per-channel frequency control word, unsigned
i_mode  in  2  waveform: 0 saw, 1 square, 2 triangle, 3 silence
i_atten  in  4  attenuation as an arithmetic right shift, 0..15
i_sync  in  1  single-cycle pulse; clears all phase accumulators
i_sample_req  in  1  single-cycle request for one sample frame
o_sample  out  NUM_CH*SAMPLE_W  packed signed samples
o_valid  out  1  one-cycle strobe; o_sample is new this cycle

Behaviour:
- Reset (async assert, release sync to i_clk): all phase accumulators = 0, all pipeline registers = 0, o_sample = 0, o_valid = 0. Reset mid-pipeline discards in-flight samples; no o_valid follows.
- Phase update on i_sample_req=1: phase[c] <= phase[c] + fcw[c], mod 2^PHASE_W (wraps silently, no saturation). With no request, the phase holds.
- The sample is computed from the pre-increment phase, i.e. the value held in the request cycle.
- i_sync=1 with no request: phase[c] <= 0.
- i_sync=1 and i_sample_req=1 in the same cycle: the sample is computed from phase 0, then phase[c] <= fcw[c]. Sync wins.
- Waveforms use p = phase[PHASE_W-1 -: SAMPLE_W] and m = phase MSB.
  - saw: p with its MSB inverted, i.e. p - 2^(SAMPLE_W-1).
  - square: m=0 gives +(2^(SAMPLE_W-1)-1); m=1 gives -(2^(SAMPLE_W-1)-1). The output is symmetric and never reaches the most-negative code.
  - triangle: q = phase[PHASE_W-2 -: SAMPLE_W]; if m=1 then q = ~q; output is q with its MSB inverted.
  - silence: 0. Phase still advances.
- Pipeline stage 1 (request cycle N): register the per-channel waveform value, i_atten and the valid bit. i_mode and i_atten are sampled only in cycle N; changes at other times have no effect on that sample.
- Pipeline stage 2 (cycle N+1): o_sample[c] <= wave[c] >>> atten, arithmetic shift with sign preserved.
- o_valid is high in cycle N+2 only. Latency from request to valid is 2 cycles.
- Requests may arrive every cycle. Throughput is one frame per cycle with no stall and no drop. Each request yields exactly one o_valid, in order.
- o_sample holds its last value between valids.
- Channels are independent: equal FCWs give identical samples; differing FCWs never interact.

Test Plan:
1. Reset, then saw mode, atten 0, fcw0=0x400000, fcw1=0x800000, and 4 requests spaced 5 cycles apart. Required: each o_valid exactly 2 cycles after its request. ch0 = 0x8000, 0xC000, 0x0000, 0x4000. ch1 = 0x8000, 0x0000, 0x8000, 0x0000.
2. Square and triangle, fcw=0x200000 with 8 back-to-back requests. Required: 8 consecutive valid cycles. Square = 0x7FFF x4, then 0x8001 x4. Triangle = 0x8000, 0xC000, 0x0000, 0x4000, 0x7FFF, 0x3FFF, 0xFFFF, 0xBFFF.
3. Attenuation: square mode, phase 0, atten=1 then atten=15. Required: 0x3FFF then 0x0000. With m=1 and atten=1: 0xC000, sign preserved.
4. Wrap and sync: fcw=0xFFFFFF, saw mode. Required: after 1 request the next sample is 0x7FFF, because phase wrapped to 0xFFFFFF. Then i_sync together with a request: that sample is 0x8000 and the next is 0x7FFF.
5. Mode change: mode switched saw to silence in the cycle after a request. Required: that sample is still a saw value. Later samples are 0 while the phase keeps advancing. Returning to saw resumes at the expected advanced phase.
6. Reset mid-flight: assert i_rst the cycle after a request. Required: o_valid never pulses, o_sample = 0, phase = 0. The first request after release yields 0x8000 (saw).
